vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//   Timing source for the video path. Scans pixel_x/pixel_y across a 640x480 @60 Hz frame.
//   Drives the hsync/vsync pins and asserts video_on inside the visible region.
//   Downstream pixel generators consume pixel_x, pixel_y and video_on directly.
// PARAMETERS
//   CLK_DIV    4    clk cycles per pixel (100 MHz -> 25 MHz); legal 1..16
//   H_DISPLAY  640  visible pixels per line
//   H_FRONT    16   horizontal front porch, pixels
//   H_SYNC     96   hsync pulse width, pixels
//   H_BACK     48   horizontal back porch, pixels
//   V_DISPLAY  480  visible lines per frame
//   V_FRONT    10   vertical front porch, lines
//   V_SYNC     2    vsync pulse width, lines
//   V_BACK     33   vertical back porch, lines
//   H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; both must be <= 1024
// PORTS
//   clk        in   1   system clock, 100 MHz
//   reset      in   1   synchronous, active-high reset
//   p_tick     out  1   one-clk pixel-enable strobe, every CLK_DIV clks
//   pixel_x    out  10  horizontal count, 0..H_TOTAL-1
//   pixel_y    out  10  vertical count, 0..V_TOTAL-1
//   video_on   out  1   1 when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
//   hsync      out  1   horizontal sync, active level per CONFIGURATION
//   vsync      out  1   vertical sync, active level per CONFIGURATION
//   frame_end  out  1   one-clk pulse on the p_tick that leaves (H_TOTAL-1,V_TOTAL-1)
// BEHAVIOUR
//   - Prescaler div_cnt (4 bits): 0..CLK_DIV-1, wraps to 0.
//     p_tick = (div_cnt==CLK_DIV-1), combinational; CLK_DIV=1 -> p_tick constant 1.
//   - h_cnt advances only on p_tick; at H_TOTAL-1 it wraps to 0 on the same edge.
//   - v_cnt advances only on p_tick with h_cnt==H_TOTAL-1; at V_TOTAL-1 it wraps to 0.
//   - pixel_x = h_cnt and pixel_y = v_cnt, driven directly from the registers.
//   - hsync, vsync and video_on are registers computed from the next-state counts.
//     They are therefore always cycle-aligned with pixel_x/pixel_y (no one-pixel skew).
//   - hsync is active for h_cnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]
//     (defaults 656..751).
//   - vsync is active for v_cnt in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]
//     (defaults 490..491).
//   - frame_end = p_tick & h_cnt==H_TOTAL-1 & v_cnt==V_TOTAL-1, combinational.
//   - Reset values: div_cnt=0, pixel_x=0, pixel_y=0, video_on=0, hsync/vsync inactive.
//     p_tick=0 unless CLK_DIV=1; frame_end=0.
//   - First edge with reset low: counts still 0, video_on->1, syncs stay inactive.
//   - Reset mid-frame: all of the above on the next edge regardless of position.
//     No partial line or frame is completed.
//   - Default frame: 800x525 pixels = 420000 p_ticks = 1,680,000 clk.
// CONFIGURATION
//   VGA_SYNC_ACTIVE_HIGH_EN
//     defined:   hsync/vsync are 1 during the sync window, 0 otherwise; reset value 0.
//     undefined: active-low (VGA 640x480 standard); 1 outside window; reset value 1.
//   No other port or timing behaviour changes.
// TESTING
//   1. Reset 3 clks, release -> p_tick every 4th clk; pixel_x 0,1,2.. per tick;
//      video_on=1 from first edge.
//   2. Run one line -> hsync low exactly 96 ticks for pixel_x 656..751;
//      video_on=0 for x>=640; x wraps 799->0 and y increments 0->1.
//   3. Run one frame -> vsync low for pixel_y 490..491 only; frame_end pulses once,
//      on the p_tick at (799,524), 1,680,000 clk after reset release; next state (0,0).
//   4. Assert reset at (300,200) for 1 clk -> next edge: (0,0), video_on=0,
//      hsync=vsync=1; resumes as in 1.
//   5. CLK_DIV=1 -> p_tick stuck 1; frame_end period = 420000 clk.
//   6. Rebuild with VGA_SYNC_ACTIVE_HIGH_EN -> scenario 2/3 windows identical
//      with inverted levels; reset value 0.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA 640x480 timing generator: prescaled pixel strobe, x/y scan, registered syncs.
// Define VGA_SYNC_ACTIVE_HIGH_EN for active-high hsync/vsync (default active-low).
module vga_sync_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_end
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_BEG   = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_BEG   = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
   localparam logic SYNC_ON = 1'b1;
`else
   localparam logic SYNC_ON = 1'b0;
`endif

   logic [3:0] div_cnt;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   logic       h_end;
   logic       v_end;

   assign p_tick    = (div_cnt == DIV_LAST);
   assign h_end     = (h_cnt == H_LAST);
   assign v_end     = (v_cnt == V_LAST);
   assign frame_end = p_tick & h_end & v_end;
   assign pixel_x   = h_cnt;
   assign pixel_y   = v_cnt;

   always_comb begin
      h_nxt = h_cnt;
      v_nxt = v_cnt;
      if (p_tick) begin
         if (h_end) begin
            h_nxt = '0;
            v_nxt = v_end ? '0 : v_cnt + 10'd1;
         end else begin
            h_nxt = h_cnt + 10'd1;
         end
      end
   end

   // Syncs and blanking use next-state counts so they line up with pixel_x/y.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt  <= '0;
         h_cnt    <= '0;
         v_cnt    <= '0;
         video_on <= 1'b0;
         hsync    <= ~SYNC_ON;
         vsync    <= ~SYNC_ON;
      end else begin
         div_cnt  <= p_tick ? 4'd0 : div_cnt + 4'd1;
         h_cnt    <= h_nxt;
         v_cnt    <= v_nxt;
         video_on <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
         hsync    <= (h_nxt >= HS_BEG && h_nxt <= HS_END)
                     ? SYNC_ON : ~SYNC_ON;
         vsync    <= (v_nxt >= VS_BEG && v_nxt <= VS_END)
                     ? SYNC_ON : ~SYNC_ON;
      end
   end

endmodule
